// File: rtl/exec_ctrl_if.sv
// exec_ctrl_if: decoder/core-side enables and PC seen by the execution sequencer
interface exec_ctrl_if #(parameter int PC_W = 9);
  logic [PC_W-1:0] pc_i;
  logic [PC_W-1:0] end_pc;
  logic dec_pc_we;
  logic dec_reg_we;
  logic dec_mem_we;
  logic pc_we;
  logic reg_we;
  logic mem_we;
  modport master (
    output pc_i, end_pc, dec_pc_we, dec_reg_we, dec_mem_we,
    input  pc_we, reg_we, mem_we
  );
  modport slave (
    input  pc_i, end_pc, dec_pc_we, dec_reg_we, dec_mem_we,
    output pc_we, reg_we, mem_we
  );
endinterface

// File: rtl/exec_ctrl.sv
// exec_ctrl: run/halt/single-step sequencer gating decoder write enables; EXEC_BKPT_EN adds a PC breakpoint
module exec_ctrl #(
  parameter int PC_W  = 9,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             step_i,
`ifdef EXEC_BKPT_EN
  input  logic             bkpt_en,
  input  logic [PC_W-1:0]  bkpt_pc,
`endif
  exec_ctrl_if.slave       bus,
  output logic             running,
  output logic             done,
  output logic [CYC_W-1:0] cyc_cnt
);
  typedef enum logic [2:0] {IDLE, RUN, STEP, HALT, DONE} state_t;
  state_t state, nxt;
  logic [2:0] s1, s2, s3, evt;
  logic stop_e, step_e, start_e, hit, bk, en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {stop_i, step_i, start_i};
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign evt = s2 & ~s3;
  assign {stop_e, step_e, start_e} = evt;
  assign hit = bus.pc_i == bus.end_pc;
`ifdef EXEC_BKPT_EN
  logic skip;
  assign bk = bkpt_en && bus.pc_i == bkpt_pc && !skip;
  // skip lets the instruction sitting on the breakpoint run once after a resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip <= 1'b0;
    else if (state == HALT && nxt != HALT) skip <= 1'b1;
    else if (en) skip <= 1'b0;
  end
`else
  assign bk = 1'b0;
`endif
  assign en = (state == RUN && !hit && !bk) || state == STEP;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, HALT: nxt = step_e ? STEP : start_e ? RUN : state;
      RUN:        nxt = stop_e ? HALT : bk ? HALT : hit ? DONE : RUN;
      STEP:       nxt = HALT;
      default:    nxt = DONE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_cnt <= '0;
    else if (en && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
  end
  assign bus.pc_we  = bus.dec_pc_we & en;
  assign bus.reg_we = bus.dec_reg_we & en;
  assign bus.mem_we = bus.dec_mem_we & en;
  assign running = state == RUN;
  assign done    = state == DONE;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: directed bench with an execution scoreboard popped on every gated pc_we
module tb_exec_ctrl;
  localparam logic [2:0] START = 3'b001, STEP = 3'b010, STOP = 3'b100;
  logic clk, rst_n;
  logic [2:0] req;
  logic [2:0] dec;
  logic [8:0] pc, end_pc;
  logic running, done, run_b, done_b;
  logic [15:0] cyc;
  logic [2:0] cyc_b;
  int checks = 0, errors = 0;
  typedef struct {int pc; int cnt;} exp_t;
  exp_t q[$];
  exec_ctrl_if #(.PC_W(9)) ifa ();
  exec_ctrl_if #(.PC_W(9)) ifb ();
  assign ifa.pc_i = pc;
  assign ifa.end_pc = end_pc;
  assign {ifa.dec_pc_we, ifa.dec_reg_we, ifa.dec_mem_we} = dec;
  assign ifb.pc_i = pc;
  assign ifb.end_pc = end_pc;
  assign {ifb.dec_pc_we, ifb.dec_reg_we, ifb.dec_mem_we} = dec;
`ifdef EXEC_BKPT_EN
  logic bkpt_en;
  logic [8:0] bkpt_pc;
`endif
  exec_ctrl #(.PC_W(9), .CYC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(req[0]), .stop_i(req[2]), .step_i(req[1]),
`ifdef EXEC_BKPT_EN
    .bkpt_en(bkpt_en), .bkpt_pc(bkpt_pc),
`endif
    .bus(ifa), .running(running), .done(done), .cyc_cnt(cyc)
  );
  exec_ctrl #(.PC_W(9), .CYC_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(req[0]), .stop_i(req[2]), .step_i(req[1]),
`ifdef EXEC_BKPT_EN
    .bkpt_en(bkpt_en), .bkpt_pc(bkpt_pc),
`endif
    .bus(ifb), .running(run_b), .done(done_b), .cyc_cnt(cyc_b)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else if (ifa.pc_we) pc <= pc + 1'b1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && ifa.pc_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exec actual pc %0d expected no execution", pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("exec_pc", 32'(pc), e.pc);
        chk("exec_cnt", 32'(cyc), e.cnt);
      end
    end
  end
  task automatic expect_run(input int from, input int n);
    for (int i = 0; i < n; i++) q.push_back('{from + i, from + i});
  endtask
  task automatic pulse(input logic [2:0] r);
    @(negedge clk) req = r;
    @(negedge clk) req = '0;
  endtask
  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    req = '0;
    dec = 3'b111;
    end_pc = 9'd5;
`ifdef EXEC_BKPT_EN
    bkpt_en = 1'b0;
    bkpt_pc = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t1_pc_we", 32'(ifa.pc_we), 0);
    chk("t1_reg_we", 32'(ifa.reg_we), 0);
    chk("t1_mem_we", 32'(ifa.mem_we), 0);
    chk("t1_cyc", 32'(cyc), 0);
    chk("t1_running", 32'(running), 0);
    expect_run(0, 5);
    pulse(START);
    chk("t2_not_yet", 32'(running), 0);
    repeat (2) @(negedge clk);
    chk("t2_running", 32'(running), 1);
    dec = 3'b101;
    #1;
    chk("t2_pc_we", 32'(ifa.pc_we), 1);
    chk("t2_reg_we_gated", 32'(ifa.reg_we), 0);
    chk("t2_mem_we", 32'(ifa.mem_we), 1);
    dec = 3'b111;
    repeat (10) @(negedge clk);
    chk("t2_done", 32'(done), 1);
    chk("t2_running_off", 32'(running), 0);
    chk("t2_cyc", 32'(cyc), 5);
    chk("t2_pc", 32'(pc), 5);
    chk("t2_pc_we_at_end", 32'(ifa.pc_we), 0);
    pulse(START);
    pulse(STEP);
    repeat (6) @(negedge clk);
    chk("t2_done_sticky", 32'(done), 1);
    chk("t2_cyc_sticky", 32'(cyc), 5);
    do_reset();
    end_pc = 9'd100;
    expect_run(0, 5);
    pulse(START);
    repeat (3) @(negedge clk);
    pulse(STOP);
    repeat (6) @(negedge clk);
    chk("t3_halt_running", 32'(running), 0);
    chk("t3_halt_done", 32'(done), 0);
    chk("t3_halt_cyc", 32'(cyc), 5);
    chk("t3_sat_cyc5", 32'(cyc_b), 5);
    expect_run(5, 1);
    pulse(STEP);
    repeat (6) @(negedge clk);
    chk("t3_step_cyc", 32'(cyc), 6);
    chk("t3_step_running", 32'(running), 0);
    expect_run(6, 1);
    @(negedge clk) req = STEP;
    repeat (10) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    chk("t3_hold_cyc", 32'(cyc), 7);
    chk("t5_sat_cyc7", 32'(cyc_b), 7);
    expect_run(7, 5);
    pulse(START);
    repeat (3) @(negedge clk);
    pulse(STOP | STEP | START);
    repeat (6) @(negedge clk);
    chk("t4_halt_running", 32'(running), 0);
    chk("t4_halt_cyc", 32'(cyc), 12);
    repeat (5) @(negedge clk);
    chk("t4_frozen_cyc", 32'(cyc), 12);
    expect_run(12, 5);
    pulse(START);
    repeat (2) @(negedge clk);
    chk("t4_resumed", 32'(running), 1);
    @(negedge clk);
    pulse(STOP);
    repeat (6) @(negedge clk);
    chk("t4_resume_cyc", 32'(cyc), 17);
    chk("t5_sat_hold", 32'(cyc_b), 7);
    do_reset();
    expect_run(0, 3);
    pulse(START);
    repeat (4) @(negedge clk);
    chk("t5_pre_pc_we", 32'(ifa.pc_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_pc_we", 32'(ifa.pc_we), 0);
    chk("t5_async_reg_we", 32'(ifa.reg_we), 0);
    chk("t5_async_mem_we", 32'(ifa.mem_we), 0);
    chk("t5_async_running", 32'(running), 0);
    chk("t5_async_cyc", 32'(cyc), 0);
    @(negedge clk) rst_n = 1'b1;
`ifdef EXEC_BKPT_EN
    do_reset();
    end_pc = 9'd8;
    bkpt_en = 1'b1;
    bkpt_pc = 9'd3;
    expect_run(0, 3);
    pulse(START);
    repeat (8) @(negedge clk);
    chk("t6_bkpt_running", 32'(running), 0);
    chk("t6_bkpt_done", 32'(done), 0);
    chk("t6_bkpt_cyc", 32'(cyc), 3);
    chk("t6_bkpt_pc", 32'(pc), 3);
    expect_run(3, 5);
    pulse(START);
    repeat (12) @(negedge clk);
    chk("t6_end_done", 32'(done), 1);
    chk("t6_end_cyc", 32'(cyc), 8);
`endif
    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
